// File: rtl/avalon_uart_tx_slave_if.sv
// Avalon-MM register port between the Nios II master and the UART TX slave.
interface avalon_uart_tx_slave_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/avalon_uart_tx_slave.sv
// Avalon-MM slave with a TX FIFO feeding an 8N1 UART serialiser.
// Registers: 0 TXDATA, 1 STATUS, 2 CONTROL, 3 reserved; read latency 1.
module avalon_uart_tx_slave #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned UART_BPS   = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    avalon_uart_tx_slave_if.slave  avs,
    output logic                   uart_txd
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int unsigned CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned FW       = AW + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e         state_q,   state_d;
    logic [CW-1:0]  baud_q,    baud_d;
    logic [2:0]     bit_q,     bit_d;
    logic [7:0]     shift_q,   shift_d;
    logic           txd_q,     txd_d;
    logic [AW-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [FW-1:0]  fill_q,    fill_d;
    logic           overflow_q, overflow_d;
    logic           tx_en_q,   tx_en_d;
    logic [31:0]    rdata_q,   rdata_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic wr_txdata_c, wr_status_c, wr_control_c;
    logic full_c, empty_c, push_c, pop_c, flush_c, baud_end_c, busy_c;
    logic unused_wdata;

    assign unused_wdata = ^avs.avs_writedata[31:8];

    // Decode and FIFO handshake; full is judged on the pre-pop fill level
    always_comb begin
        wr_txdata_c  = avs.avs_write && (avs.avs_address == 2'd0);
        wr_status_c  = avs.avs_write && (avs.avs_address == 2'd1);
        wr_control_c = avs.avs_write && (avs.avs_address == 2'd2);
        full_c       = (fill_q == FILL_FULL);
        empty_c      = (fill_q == '0);
        push_c       = wr_txdata_c && !full_c;
        flush_c      = wr_control_c && avs.avs_writedata[1];
        baud_end_c   = (baud_q == BAUD_LAST);
        busy_c       = (state_q != S_IDLE);
        pop_c        = tx_en_q && !empty_c &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end_c));
    end

    // FIFO pointers, fill level and control/status bits
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        tx_en_d    = tx_en_q;
        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            fill_d = fill_q + FW'(push_c) - FW'(pop_c);
        end
        if (wr_txdata_c && full_c)
            overflow_d = 1'b1;
        else if (wr_status_c && avs.avs_writedata[3])
            overflow_d = 1'b0;
        if (wr_control_c)
            tx_en_d = avs.avs_writedata[0];
    end

    // Serialiser; the STOP-to-START path keeps queued frames gapless
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    state_d = S_START;
                    baud_d  = '0;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    if (pop_c) begin
                        state_d = S_START;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        txd_d = 1'b1;
        if (state_d == S_START)     txd_d = 1'b0;
        else if (state_d == S_DATA) txd_d = shift_d[0];
    end

    // Read mux; a colliding write wins and the read returns zero
    always_comb begin
        rdata_d = '0;
        if (avs.avs_read && !avs.avs_write) begin
            unique case (avs.avs_address)
                2'd1:    rdata_d = {16'h0, 8'(fill_q), 4'h0, overflow_q, busy_c, empty_c, full_c};
                2'd2:    rdata_d = {31'h0, tx_en_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage needs no reset: entries are only read once pushed
    always_ff @(posedge sys_clk) begin
        if (push_c && !flush_c)
            mem_q[wr_ptr_q] <= avs.avs_writedata[7:0];
    end

    assign uart_txd         = txd_q;
    assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_avalon_uart_tx_slave.sv
// Directed bench for avalon_uart_tx_slave at default parameters (868 clocks per bit).
module tb_avalon_uart_tx_slave;

    localparam int BAUD = 868;
    localparam int HALF = 434;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic uart_txd;
    int   n_pass  = 0;
    int   n_total = 0;

    avalon_uart_tx_slave_if avs ();

    avalon_uart_tx_slave dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .avs      (avs),
        .uart_txd (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs.avs_address   = a;
        avs.avs_writedata = d;
        avs.avs_write     = 1'b1;
        tick();
        avs.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs.avs_address = a;
        avs.avs_read    = 1'b1;
        tick();
        avs.avs_read    = 1'b0;
        d = avs.avs_readdata;
    endtask

    // Waits up to max_wait cycles for a start bit, then checks all ten bits mid-cell
    task automatic expect_frame(input logic [7:0] b, input int max_wait, input string nm);
        logic [9:0] exp_bits;
        int n;
        exp_bits = {1'b1, b, 1'b0};
        n = 0;
        while (uart_txd !== 1'b0 && n < max_wait) begin
            tick();
            n++;
        end
        n_total++;
        if (uart_txd !== 1'b0) begin
            $display("FAIL %s_start: txd=%b after %0d cycles, required 0", nm, uart_txd, n);
            return;
        end
        n_pass++;
        for (int k = 0; k < 10; k++) begin
            repeat (HALF) tick();
            n_total++;
            if (uart_txd !== exp_bits[k])
                $display("FAIL %s_bit%0d: txd=%b, required %b", nm, k, uart_txd, exp_bits[k]);
            else
                n_pass++;
            repeat (BAUD - HALF) tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        sys_rst = 1'b1;
        repeat (3) tick();
        n_total++;
        if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b, required 1", uart_txd);
        else n_pass++;
        n_total++;
        if (avs.avs_readdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", avs.avs_readdata);
        else n_pass++;
        sys_rst = 1'b0;
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL reset_status: got %h, required 00000002", rd);
        else n_pass++;
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reset_control: got %h, required 0", rd);
        else n_pass++;
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL control_rw: got %h, required 1", rd);
        else n_pass++;
        tick();
        n_total++;
        if (avs.avs_readdata !== 32'h0) $display("FAIL rdata_idle: got %h, required 0", avs.avs_readdata);
        else n_pass++;
        bus_read(2'd0, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL txdata_read: got %h, required 0", rd);
        else n_pass++;
        bus_read(2'd3, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reg3_read: got %h, required 0", rd);
        else n_pass++;
        avs.avs_address   = 2'd2;
        avs.avs_writedata = 32'h0;
        avs.avs_write     = 1'b1;
        avs.avs_read      = 1'b1;
        tick();
        avs.avs_write = 1'b0;
        avs.avs_read  = 1'b0;
        n_total++;
        if (avs.avs_readdata !== 32'h0) $display("FAIL rw_collision: got %h, required 0", avs.avs_readdata);
        else n_pass++;
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL collision_write: got %h, required 0", rd);
        else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [31:0] rd;
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'h55);
        fork
            expect_frame(8'h55, 5, "single");
            begin
                repeat (100) tick();
                bus_read(2'd1, rd);
                n_total++;
                if (rd !== 32'h0000_0006) $display("FAIL single_busy: got %h, required 00000006", rd);
                else n_pass++;
            end
        join
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL single_done: got %h, required 00000002", rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp_st [3];
        logic [7:0]  bytes  [3];
        exp_st = '{32'h0000_0204, 32'h0000_0104, 32'h0000_0006};
        bytes  = '{8'h41, 8'h42, 8'h43};
        bus_write(2'd2, 32'h0);
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'(bytes[i]));
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0300) $display("FAIL b2b_fill3: got %h, required 00000300", rd);
        else n_pass++;
        bus_write(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) begin
            fork
                expect_frame(bytes[i], (i == 0) ? 5 : 0, "b2b");
                begin
                    repeat (4) tick();
                    bus_read(2'd1, rd);
                    n_total++;
                    if (rd !== exp_st[i]) $display("FAIL b2b_status%0d: got %h, required %h", i, rd, exp_st[i]);
                    else n_pass++;
                end
            join
        end
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL b2b_done: got %h, required 00000002", rd);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(2'd2, 32'h0);
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_1001) $display("FAIL ovf_full: got %h, required 00001001", rd);
        else n_pass++;
        bus_write(2'd0, 32'hEE);
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_1009) $display("FAIL ovf_set: got %h, required 00001009", rd);
        else n_pass++;
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_1001) $display("FAIL ovf_clear: got %h, required 00001001", rd);
        else n_pass++;
        bus_write(2'd2, 32'h2);
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL ovf_flush: got %h, required 00000002", rd);
        else n_pass++;
        n_total++;
        if (uart_txd !== 1'b1) $display("FAIL ovf_txd_idle: got %b, required 1", uart_txd);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        logic [7:0]  bytes [5];
        int lows;
        bytes = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        bus_write(2'd2, 32'h0);
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'(bytes[i]));
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0500) $display("FAIL flush_fill5: got %h, required 00000500", rd);
        else n_pass++;
        bus_write(2'd2, 32'h1);
        fork
            expect_frame(8'hA5, 5, "flush");
            begin
                repeat (1000) tick();
                bus_write(2'd2, 32'h3);
                bus_read(2'd1, rd);
                n_total++;
                if (rd !== 32'h0000_0006) $display("FAIL flush_empty: got %h, required 00000006", rd);
                else n_pass++;
            end
        join
        lows = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (uart_txd !== 1'b1) lows++;
        end
        n_total++;
        if (lows != 0) $display("FAIL flush_no_more: %0d low cycles, required 0", lows);
        else n_pass++;
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL flush_status: got %h, required 00000002", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int n;
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'hF0);
        n = 0;
        while (uart_txd !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        repeat (3 * BAUD + HALF) tick();
        n_total++;
        if (uart_txd !== 1'b0) $display("FAIL rstmid_pre: txd=%b, required 0", uart_txd);
        else n_pass++;
        sys_rst = 1'b1;
        tick();
        n_total++;
        if (uart_txd !== 1'b1) $display("FAIL rstmid_txd: got %b, required 1", uart_txd);
        else n_pass++;
        sys_rst = 1'b0;
        bus_read(2'd1, rd);
        n_total++;
        if (rd !== 32'h0000_0002) $display("FAIL rstmid_status: got %h, required 00000002", rd);
        else n_pass++;
        bus_read(2'd2, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL rstmid_control: got %h, required 0", rd);
        else n_pass++;
        repeat (50) tick();
        n_total++;
        if (uart_txd !== 1'b1) $display("FAIL rstmid_idle: got %b, required 1", uart_txd);
        else n_pass++;
    endtask

    initial begin
        avs.avs_address   = 2'd0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = 32'h0;
        avs.avs_read      = 1'b0;
        test_reset();
        test_regs();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
